bus_arbiter_rr: RTL
===================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 4, giving the number of requesting masters (2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the cycles a grant may wait for bus_ack; 0 disables the timeout.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port rr_en, input, 1 bit: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
REQ-006 The block SHALL have port bus_req, input, N_MASTERS bits, one request bit per master.
REQ-007 The block SHALL have port bus_ack, input, 1 bit, the bus end-of-transfer acknowledge.
REQ-008 The block SHALL have port bus_grant, output, N_MASTERS bits, the registered one-hot or all-zero grant.
REQ-009 The block SHALL have port grant_id, output, clog2(N_MASTERS) bits, the registered index of the granted master (0 when no grant).
REQ-010 The block SHALL have port busy, output, 1 bit, high while in state BUSY.
REQ-011 The block SHALL have port timeout, output, 1 bit, a one-cycle pulse when a grant is revoked for lack of bus_ack.

Function
REQ-012 The FSM SHALL have states READY and BUSY.
REQ-013 In READY with bus_req nonzero, the next edge SHALL load bus_grant with the picked master, set grant_id and move to BUSY (1-cycle latency).
REQ-014 In READY with bus_req zero, the block SHALL stay in READY with bus_grant = 0.
REQ-015 In BUSY without bus_ack, bus_grant SHALL hold unchanged regardless of bus_req changes.
REQ-016 In BUSY with bus_ack and bus_req nonzero, the next edge SHALL load a newly picked grant and stay in BUSY (back-to-back, no idle cycle).
REQ-017 In BUSY with bus_ack and bus_req zero, the next edge SHALL clear bus_grant and return to READY.
REQ-018 Fixed-priority mode SHALL pick the lowest-index asserted request.
REQ-019 Round-robin mode SHALL pick the first asserted request scanning upward from (last_grant+1) mod N_MASTERS, wrapping from N_MASTERS-1 to 0.
REQ-020 last_grant SHALL update on every grant load in both modes, so toggling rr_en takes effect at the next pick without reset.
REQ-021 A wait counter SHALL clear on every grant load and increment each BUSY cycle without bus_ack.
REQ-022 When TIMEOUT>0 and the counter reaches TIMEOUT-1 without bus_ack, the next edge SHALL clear bus_grant, pulse timeout for one cycle, set last_grant to the revoked master and go to READY.
REQ-023 bus_ack in the same cycle as timeout expiry SHALL win: no timeout pulse, normal REQ-016/017 behaviour.
REQ-024 bus_ack in READY SHALL be ignored.
REQ-025 The wait counter SHALL saturate and never wrap; its width SHALL be clog2(TIMEOUT+1).

Reset
REQ-026 On reset_n low, asynchronously: state READY, bus_grant 0, grant_id 0, busy 0, timeout 0, counter 0, last_grant N_MASTERS-1 (first round-robin pick scans from master 0).
REQ-027 Reset asserted mid-grant SHALL drop bus_grant immediately, without waiting for a clock edge.
REQ-028 The first edge after reset_n rises SHALL behave as READY.

Structure
REQ-029 The shared package arbitration SHALL hold N_MASTERS default, the arb_vector type, NO_GRANT, NO_REQUEST and the state enum arb_state_t {READY, BUSY}.
REQ-030 The pick logic SHALL be a combinational sub-module arb_rr_picker (inputs req, start index, rr_en; outputs one-hot grant and index); this sub-module holds no state.

Verification (N_MASTERS=4, TIMEOUT=8)
REQ-031 Fixed priority: rr_en=0, bus_req=4'b1010 held, bus_ack pulsed every 3 cycles -> bus_grant=0010 every time.
REQ-032 Round-robin: rr_en=1, bus_req=4'b1111 held, bus_ack every cycle in BUSY -> grants 0001,0010,0100,1000,0001 on consecutive edges.
REQ-033 Timeout: bus_req=0100, no bus_ack -> grant 0100 for 8 cycles, then bus_grant=0, timeout=1 for one cycle, busy=0.
REQ-034 Ack/timeout race: bus_ack asserted exactly in the expiry cycle with bus_req=0000 -> timeout stays 0, bus_grant=0, state READY.
REQ-035 Async reset: reset_n pulled low between edges while bus_grant=1000 -> bus_grant=0 before the next edge; after release with bus_req=1111 and rr_en=1, the first grant is 0001.
REQ-036 Mode switch: rr_en=1 with last grant 0010, then rr_en=0 with bus_req=0101 -> grant 0001; back to rr_en=1 with bus_req=0101 -> grant 0100.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared arbitration types: default master count, request/grant vector,
// empty-vector constants and the arbiter state encoding.
package arbitration;

  localparam int unsigned N_MASTERS_DEF = 4;

  typedef logic [N_MASTERS_DEF-1:0] arb_vector;

  localparam arb_vector NO_GRANT   = '0;
  localparam arb_vector NO_REQUEST = '0;

  typedef enum logic {
    READY = 1'b0,
    BUSY  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Stateless request picker: fixed priority from index 0, or round-robin
// scanning upward from start_i with wrap-around.
module arb_rr_picker #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic          rr_en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int unsigned   sum;
  logic [IW-1:0] cand;
  logic          found;

  // First asserted request in scan order wins; nothing asserted gives all-zero.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = 0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = int'(start_i) + i;
      if (sum >= N) sum = sum - N;
      cand = rr_en_i ? IW'(sum) : IW'(i);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Bus arbiter with round-robin / fixed-priority selection, back-to-back
// grants on bus_ack and an optional grant timeout.
module bus_arbiter_rr
  import arbitration::*;
#(
  parameter  int unsigned N_MASTERS = N_MASTERS_DEF,
  parameter  int unsigned TIMEOUT   = 16,
  localparam int unsigned IW        = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rr_en,
  input  logic [N_MASTERS-1:0] bus_req,
  input  logic                 bus_ack,
  output logic [N_MASTERS-1:0] bus_grant,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW > 0) ? CW_RAW : 1;
  localparam int unsigned T_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]        id_q, id_d;
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 to_q, to_d;

  logic [IW-1:0]        start_idx;
  logic [N_MASTERS-1:0] pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 any_req;
  logic                 expired;

  assign start_idx = (last_q == IW'(N_MASTERS - 1)) ? '0 : last_q + IW'(1);
  assign any_req   = |bus_req;
  assign expired   = (TIMEOUT > 0) && (cnt_q == CW'(T_LAST));

  arb_rr_picker #(.N(N_MASTERS)) u_picker (
    .req_i   (bus_req),
    .start_i (start_idx),
    .rr_en_i (rr_en),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      READY: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = pick_grant;
          id_d    = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end else begin
          grant_d = '0;
          id_d    = '0;
        end
      end
      BUSY: begin
        // An ack in the expiry cycle takes precedence over the timeout.
        if (bus_ack) begin
          if (any_req) begin
            grant_d = pick_grant;
            id_d    = pick_idx;
            last_d  = pick_idx;
            cnt_d   = '0;
          end else begin
            state_d = READY;
            grant_d = '0;
            id_d    = '0;
          end
        end else if (expired) begin
          state_d = READY;
          grant_d = '0;
          id_d    = '0;
          last_d  = id_q;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= READY;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign bus_grant = grant_q;
  assign grant_id  = id_q;
  assign busy      = (state_q == BUSY);
  assign timeout   = to_q;

endmodule
